alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_arbiter_if.sv | 37 +++
 rtl/alu.sv | 52 +++++
 rtl/alu_arbiter_rr_arb.sv | 31 +++
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 248 ++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice: FSM state encoding,
// ALU opcode values and the round-robin pointer helper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_SHL = 4'b0000;
  localparam logic [3:0] OP_SHR = 4'b0001;
  localparam logic [3:0] OP_SRA = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;

  // Pointer value that follows a grant to requester idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between NREQ requesters and the shared-ALU arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; req_ready is only ever high for one requester, rsp_* hold until accepted.
interface alu_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*4-1:0]     req_opcode;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_y;
  logic                  rsp_cout;
  logic                  rsp_overflow;
  logic                  rsp_negative;
  logic                  rsp_zero;

  modport master (
    output req_valid, req_opcode, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_overflow,
           rsp_negative, rsp_zero
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_overflow,
           rsp_negative, rsp_zero
  );

endinterface

// File: rtl/alu.sv
// Combinational WIDTH-bit ALU: shifts, add/subtract with carry, bitwise logic.
// Unknown opcodes produce a zero result with cleared carry/overflow.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum      = '0;
    y        = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    case (opcode)
      OP_SHL: y = a << b;
      OP_SHR: y = a >> b;
      OP_SRA: y = $signed(a) >>> b;
      OP_ADD: begin
        sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        y        = sum[WIDTH-1:0];
        cout     = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      // cin acts as the inverted borrow: cin=1 gives a plain a-b.
      OP_SUB: begin
        sum      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
        y        = sum[WIDTH-1:0];
        cout     = sum[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: y = '0;
    endcase
    negative = y[WIDTH-1];
    zero     = (y == '0);
  end

endmodule

// File: rtl/alu_arbiter_rr_arb.sv
// Round-robin grant: first requester at or after ptr (ascending, wrapping)
// wins; produces a one-hot grant plus its binary index.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k >= NREQ) ? IDW'(int'(ptr) + k - NREQ) : IDW'(int'(ptr) + k);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters: IDLE grants round-robin and latches
// operands, EXEC registers the ALU result, RESP holds it until consumed.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output state_t            dbg_state
);

  localparam int IDW = $clog2(NREQ);

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  grant;
  logic             accept;

  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [IDW-1:0]   id_q;

  logic [WIDTH-1:0] alu_y;
  logic             alu_cout;
  logic             alu_ovf;
  logic             alu_neg;
  logic             alu_zero;

  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_y_q;
  logic             rsp_cout_q;
  logic             rsp_ovf_q;
  logic             rsp_neg_q;
  logic             rsp_zero_q;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_rr_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // rst_n gates ready so nothing looks accepted while reset is held.
  assign accept        = rst_n && (state_q == IDLE) && (|grant);
  assign bus.req_ready = accept ? grant : '0;

  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = bus.req_opcode[4*i +: 4];
        sel_a   = bus.req_a[WIDTH*i +: WIDTH];
        sel_b   = bus.req_b[WIDTH*i +: WIDTH];
        sel_cin = bus.req_cin[i];
      end
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .opcode   (op_q),
    .a        (a_q),
    .b        (b_q),
    .cin      (cin_q),
    .y        (alu_y),
    .cout     (alu_cout),
    .overflow (alu_ovf),
    .negative (alu_neg),
    .zero     (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            cin_q   <= sel_cin;
            id_q    <= grant_idx;
            ptr_q   <= IDW'(rr_next(int'(grant_idx), NREQ));
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_y_q     <= alu_y;
          rsp_cout_q  <= alu_cout;
          rsp_ovf_q   <= alu_ovf;
          rsp_neg_q   <= alu_neg;
          rsp_zero_q  <= alu_zero;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_y        = rsp_y_q;
  assign bus.rsp_cout     = rsp_cout_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_negative = rsp_neg_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grants, ALU results, latency, fairness,
// backpressure and reset behaviour checked against a scoreboard queue.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W   = 4;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int RW  = IDW + W + 4;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] drop;
  logic [3:0]    t_op[N];
  logic [W-1:0]  t_a[N];
  logic [W-1:0]  t_b[N];
  logic          t_cin[N];

  alu_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic c);
    int ua, ub, sa, sb, ci, r, sr, mask;
    logic [W-1:0] y;
    logic co, ov;
    mask = (1 << W) - 1;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    ci = c ? 1 : 0;
    co = 1'b0;
    ov = 1'b0;
    r  = 0;
    sr = 0;
    case (op)
      OP_SHL: r = ua << ub;
      OP_SHR: r = ua >> ub;
      OP_SRA: r = sa >>> ub;
      OP_ADD: begin
        r = ua + ub + ci; co = r[W];
        sr = sa + sb + ci; ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
      end
      OP_SUB: begin
        r = ua + (~ub & mask) + ci; co = r[W];
        sr = sa - sb - 1 + ci; ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
      end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      default: r = 0;
    endcase
    y = W'(r & mask);
    return {y, co, ov, y[W-1], (y == '0)};
  endfunction

  function automatic logic [RW-1:0] rsp_now();
    return {bus.rsp_id, bus.rsp_y, bus.rsp_cout, bus.rsp_overflow, bus.rsp_negative, bus.rsp_zero};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
    t_op[i] = op; t_a[i] = a; t_b[i] = b; t_cin[i] = c;
    bus.req_opcode[4*i +: 4] = op;
    bus.req_a[W*i +: W]      = a;
    bus.req_b[W*i +: W]      = b;
    bus.req_cin[i]           = c;
    bus.req_valid[i]         = 1'b1;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the EXEC cycle.
  task automatic issue(input string tag, input int gi);
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << gi));
    check({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
    exp_q.push_back({IDW'(gi), model(t_op[gi], t_a[gi], t_b[gi], t_cin[gi])});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_exec_state"}, 32'(dbg_state), 32'(EXEC));
    check({tag, "_exec_valid"}, 32'(bus.rsp_valid), 32'(0));
  endtask

  task automatic do_rsp(input string tag, input int hold);
    int n;
    logic [RW-1:0] exp;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 1);
    if (!bus.rsp_valid) return;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s_sb response with empty expected queue", tag);
      return;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_rsp"}, 32'(rsp_now()), 32'(exp_q[0]));
      check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'(0));
      check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'(1));
    end
    exp = exp_q.pop_front();
    check({tag, "_rsp"}, 32'(rsp_now()), 32'(exp));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'(0));
    check({tag, "_done_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_cin    = '0;
    bus.rsp_ready  = 1'b0;
    for (int i = 0; i < N; i++) begin
      t_op[i] = '0; t_a[i] = '0; t_b[i] = '0; t_cin[i] = 1'b0;
    end

    // Reset state, with requests pending so ready must still stay low.
    bus.req_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'(0));
    check("rst_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_rsp", 32'(rsp_now()), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    bus.req_valid = '0;
    rst_n = 1'b1;

    // rsp_ready outside RESP has no effect.
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rspready_state", 32'(dbg_state), 32'(IDLE));
    check("idle_rspready_valid", 32'(bus.rsp_valid), 32'(0));
    bus.rsp_ready = 1'b0;

    // Single request, then scramble inputs while the op is in flight.
    set_req(0, OP_SHL, 4'b0001, 4'b0001, 1'b0);
    issue("single", 0);
    bus.req_valid  = '0;
    bus.req_a      = '1;
    bus.req_opcode = '1;
    do_rsp("single", 0);

    // Arithmetic shift on requester 2.
    set_req(2, OP_SRA, 4'b1001, 4'b0001, 1'b0);
    issue("sra", 2);
    bus.req_valid = '0;
    do_rsp("sra", 0);

    // Pointer at 3: requester 3 wins over 1, then pointer wraps to 0 -> 1.
    set_req(1, OP_SUB, 4'b0010, 4'b0011, 1'b1);
    set_req(3, OP_ADD, 4'b0111, 4'b0001, 1'b0);
    issue("add_ovf", 3);
    bus.req_valid[3] = 1'b0;
    do_rsp("add_ovf", 0);
    issue("sub_neg", 1);
    bus.req_valid = '0;
    do_rsp("sub_neg", 0);

    // Fairness: all requesters valid from reset.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, OP_SHR, 4'b0001, 4'b0001, 1'b0);
    @(negedge clk);
    check("rst2_ready", 32'(bus.req_ready), 32'(0));
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      issue($sformatf("fair%0d", g), g % N);
      do_rsp($sformatf("fair%0d", g), 0);
    end

    // Backpressure on requester 1's response.
    set_req(1, OP_XOR, 4'b1010, 4'b0110, 1'b0);
    issue("bp", 1);
    do_rsp("bp", 5);

    // Reset during EXEC: operation discarded, pointer back to 0.
    issue("mid", 2);
    rst_n = 1'b0;
    #1;
    drop = exp_q.pop_back();
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'(0));
    check("mid_rst_ready", 32'(bus.req_ready), 32'(0));
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    check("mid_rst_noresp", 32'(bus.rsp_valid), 32'(0));
    rst_n = 1'b1;
    set_req(0, OP_AND, 4'b1100, 4'b1010, 1'b0);
    issue("post_rst", 0);

    // Reset while a response is pending clears it at once.
    @(negedge clk);
    check("resp_pending", 32'(bus.rsp_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    drop = exp_q.pop_back();
    check("resp_rst_valid", 32'(bus.rsp_valid), 32'(0));
    check("resp_rst_rsp", 32'(rsp_now()), 32'(0));
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("end_quiet", 32'(bus.rsp_valid), 32'(0));
    check("end_sb_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
